// File: rtl/aes_round_engine.sv
// aes_round_engine: iterative AES core (AES-128/192/256 selected by nk), one
// round per clock, encrypt/decrypt chosen per block, valid/ready on both ends.
// Optional build macro AES_KEY_LATCH_EN: capture keySchedule on every accept so
// the caller may change it while the block is in flight.
module aes_round_engine #(
  parameter int nk = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  mode,
  input  logic [0:127]          Message,
  input  logic [128*(nk+7)-1:0] keySchedule,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [0:127]          result,
  output logic                  busy
);

  localparam int nr = nk + 6;
  localparam int rw = $clog2(nr + 1);
  localparam int kw = 128 * (nr + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and the AES byte/column transforms
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ 8'h05);
  endfunction

  // Byte i of a block sits at [127-8*i -: 8]; column c holds bytes 4c..4c+3.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inverse);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++)
      r[127-8*i -: 8] = inverse ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inverse);
    logic [127:0] r;
    int           src;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        src = inverse ? (c - row + 4) % 4 : (c + row) % 4;
        r[127-8*(4*c+row) -: 8] = s[127-8*(4*src+row) -: 8];
      end
    end
    return r;
  endfunction

  // Circulant column mix: (2,3,1,1) forward, (e,b,d,9) inverse.
  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inverse);
    logic [127:0] r;
    logic [7:0]   coef [4];
    r = '0;
    if (inverse) begin
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        for (int j = 0; j < 4; j++)
          r[127-8*(4*c+row) -: 8] = r[127-8*(4*c+row) -: 8]
                                  ^ gf_mul(s[127-8*(4*c+(row+j)%4) -: 8], coef[j]);
      end
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t         state_q;
  state_t         state_d;
  logic [rw-1:0]  round_q;
  logic [127:0]   state_reg;
  logic           mode_q;
  logic           accept;
  logic           last;
  logic [kw-1:0]  keys;
  logic [127:0]   rk [nr+1];
  logic [rw-1:0]  key_idx;
  logic [127:0]   round_key;
  logic [127:0]   fwd_sr;
  logic [127:0]   fwd_out;
  logic [127:0]   inv_ark;
  logic [127:0]   inv_out;
  logic [127:0]   round_out;

`ifdef AES_KEY_LATCH_EN
  logic [kw-1:0] key_q;

  // Snapshot the key schedule on accept so rounds are immune to later changes.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: this is plain flop storage, not a RAM, so it takes a reset value
    // like any other register and carries no stale key across a reset.
    if (!reset) key_q <= '0;
    else if (accept) key_q <= keySchedule;
  end

  assign keys = key_q;
`else
  assign keys = keySchedule;
`endif

  assign last = (round_q == rw'(nr));

  // Slice the flat key bus into round keys and pick the one this round uses.
  always_comb begin
    for (int k = 0; k <= nr; k++) rk[k] = keys[128*k +: 128];
    key_idx   = mode_q ? (rw'(nr) - round_q) : round_q;
    round_key = rk[key_idx];
  end

  // One forward or inverse round of the currently held block.
  always_comb begin
    fwd_sr    = shift_rows(sub_bytes(state_reg, 1'b0), 1'b0);
    fwd_out   = (last ? fwd_sr : mix_columns(fwd_sr, 1'b0)) ^ round_key;
    inv_ark   = sub_bytes(shift_rows(state_reg, 1'b1), 1'b1) ^ round_key;
    inv_out   = last ? inv_ark : mix_columns(inv_ark, 1'b1);
    round_out = mode_q ? inv_out : fwd_out;
  end

  // FSM next state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block gets a value before the case statement,
    // so no path through it can leave a signal unassigned and infer a latch.
    state_d   = state_q;
    in_ready  = reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    accept    = in_valid && in_ready;
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN);
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE: begin
        if (accept)         state_d = RUN;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Block register, round counter and captured mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_q   <= '0;
      state_reg <= '0;
      mode_q    <= 1'b0;
    end else if (accept) begin
      mode_q    <= mode;
      state_reg <= Message ^ (mode ? keySchedule[128*nr +: 128] : keySchedule[127:0]);
      round_q   <= rw'(1);
    end else if (state_q == RUN) begin
      state_reg <= round_out;
      if (!last) round_q <= round_q + rw'(1);
    end
  end

  assign result = state_reg;

endmodule

// File: tb/tb_aes_round_engine.sv
// tb_aes_round_engine: directed FIPS-197 vectors on three engine instances
// (nk = 4, 6, 8), plus backpressure, back-to-back, mid-run reset and key
// stability cases. Latency is counted in rising edges including the accept edge.
module tb_aes_round_engine;

  localparam logic [2047:0] sbox_tab = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] pt     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] ct128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] ct192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] ct256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] key128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] key192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] key256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          in_valid, mode, out_ready;
  logic [2:0]          in_ready, out_valid, busy;
  logic [2:0][127:0]   msg, result;
  logic [2:0][1919:0]  ks;
  int                  n_vec = 0;
  int                  n_bad = 0;
  logic [127:0]        got;

  always #5 clk = ~clk;

  aes_round_engine #(.nk(4)) u_dut4 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .mode(mode[0]), .Message(msg[0]), .keySchedule(ks[0][128*11-1:0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]), .busy(busy[0]));

  aes_round_engine #(.nk(6)) u_dut6 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .mode(mode[1]), .Message(msg[1]), .keySchedule(ks[1][128*13-1:0]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]), .busy(busy[1]));

  aes_round_engine #(.nk(8)) u_dut8 (
    .clk(clk), .reset(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .mode(mode[2]), .Message(msg[2]), .keySchedule(ks[2][128*15-1:0]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .result(result[2]), .busy(busy[2]));

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sb(input logic [7:0] b);
    return sbox_tab[2047-8*int'(b) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  // Reference key expansion; key words sit left-aligned in the 256-bit input.
  function automatic logic [1919:0] expand_key(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] sched;
    int            nr;
    nr    = nk + 6;
    sched = '0;
    rc    = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      sched[128*(i/4) + 127 - 32*(i%4) -: 32] = w[i];
    end
    return sched;
  endfunction

  // Offer one block and let it be accepted; returns just after the accept edge.
  task automatic send(input int ch, input logic m, input logic [127:0] data);
    int waited = 0;
    @(negedge clk);
    while (!in_ready[ch] && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready before accept", 128'(in_ready[ch]), 128'd1);
    in_valid[ch] = 1'b1;
    mode[ch]     = m;
    msg[ch]      = data;
    @(posedge clk);
    #1;
    in_valid[ch] = 1'b0;
    mode[ch]     = ~m;
    msg[ch]      = ~data;
    check("busy after accept", 128'(busy[ch]), 128'd1);
    check("out_valid after accept", 128'(out_valid[ch]), 128'd0);
  endtask

  // Count edges (accept edge = 1) until out_valid, bounded; returns the result.
  task automatic await_done(input int ch, input int lat, input string tag,
                            output logic [127:0] obs);
    int edges = 1;
    while (!out_valid[ch] && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    check({tag, " latency"}, 128'(edges), 128'(lat));
    check({tag, " busy at done"}, 128'(busy[ch]), 128'd0);
    obs = result[ch];
  endtask

  task automatic await_result(input int ch, input int lat, input logic [127:0] exp,
                              input string tag);
    logic [127:0] obs;
    await_done(ch, lat, tag, obs);
    check({tag, " result"}, obs, exp);
  endtask

  task automatic pop(input int ch);
    @(negedge clk);
    out_ready[ch] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[ch] = 1'b0;
    check("out_valid after pop", 128'(out_valid[ch]), 128'd0);
    check("in_ready after pop", 128'(in_ready[ch]), 128'd1);
  endtask

  task automatic run(input int ch, input logic m, input logic [127:0] data,
                     input logic [127:0] exp, input string tag);
    send(ch, m, data);
    await_result(ch, 11 + 2 * ch, exp, tag);
    pop(ch);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = '0;
    mode      = '0;
    out_ready = '0;
    msg       = '0;
    ks[0]     = expand_key({key128, 128'h0}, 4);
    ks[1]     = expand_key({key192, 64'h0}, 6);
    ks[2]     = expand_key(key256, 8);

    repeat (2) @(negedge clk);
    for (int ch = 0; ch < 3; ch++) begin
      check("reset in_ready", 128'(in_ready[ch]), 128'd0);
      check("reset out_valid", 128'(out_valid[ch]), 128'd0);
      check("reset busy", 128'(busy[ch]), 128'd0);
      check("reset result", result[ch], 128'd0);
    end
    rst_n = 1'b1;

    run(0, 1'b0, pt,    ct128, "aes128 enc");
    run(0, 1'b1, ct128, pt,    "aes128 dec");
    run(1, 1'b0, pt,    ct192, "aes192 enc");
    run(1, 1'b1, ct192, pt,    "aes192 dec");
    run(2, 1'b0, pt,    ct256, "aes256 enc");
    run(2, 1'b1, ct256, pt,    "aes256 dec");

    // Backpressure: hold the result for 5 cycles, then pop and accept together.
    send(0, 1'b0, pt);
    await_result(0, 11, ct128, "bp enc");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp result stable", result[0], ct128);
      check("bp in_ready low", 128'(in_ready[0]), 128'd0);
      check("bp out_valid held", 128'(out_valid[0]), 128'd1);
    end
    @(negedge clk);
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    mode[0]      = 1'b1;
    msg[0]       = ct128;
    #1;
    check("b2b in_ready", 128'(in_ready[0]), 128'd1);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b0;
    mode[0]      = 1'b0;
    check("b2b busy", 128'(busy[0]), 128'd1);
    check("b2b out_valid", 128'(out_valid[0]), 128'd0);
    await_result(0, 11, pt, "b2b dec");
    pop(0);

    // Reset dropped while round 5 is pending aborts the block immediately.
    send(0, 1'b0, pt);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", 128'(out_valid[0]), 128'd0);
    check("abort busy", 128'(busy[0]), 128'd0);
    check("abort in_ready", 128'(in_ready[0]), 128'd0);
    check("abort result", result[0], 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 1'b0, pt, ct128, "post-reset enc");

    // Key schedule zeroed right after accept: only a latched copy survives it.
    send(0, 1'b0, pt);
    ks[0] = '0;
`ifdef AES_KEY_LATCH_EN
    await_result(0, 11, ct128, "latched key enc");
`else
    await_done(0, 11, "unlatched key enc", got);
    check("unlatched key corrupts result", 128'(got != ct128), 128'd1);
`endif
    ks[0] = expand_key({key128, 128'h0}, 4);
    pop(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
